// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI slave frame front end.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_BUSY     = 2'd2
    } ctl_state_e;

    function automatic logic lead_is_rise(input logic cpol);
        return ~cpol;
    endfunction

    function automatic spi_mode_e mode_of(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Multi-stage synchroniser for one asynchronous pin with
//               registered previous value for rise/fall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_last;
    assign fall  = ~level & r_last;

endmodule
`default_nettype wire

// File: rtl/spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_frame
// Description : Oversampled SPI slave: captures a command word, streams a
//               per-byte receive flow and shifts a reply word out on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int IN_BYTES    = 8,
    parameter int OUT_BYTES   = 6,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            spi_clk,
    input  logic                            spi_ss,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    input  logic [OUT_BYTES*8-1:0]          cmd_write,
    output logic [IN_BYTES*8-1:0]           cmd_read,
    output logic [$clog2(IN_BYTES+1)-1:0]   cmd_len_bytes,
    output logic                            valid,
    output logic                            frame_err,
    output logic                            overflow,
    output logic [7:0]                      rx_byte,
    output logic                            rx_byte_valid,
    output logic                            busy
);

    localparam int        IN_W   = IN_BYTES * BYTE_W;
    localparam int        OUT_W  = OUT_BYTES * BYTE_W;
    localparam int        LEN_W  = $clog2(IN_BYTES + 1);
    localparam int        CNT_W  = $clog2(IN_BYTES + 2);
    localparam int        SET_W  = $clog2(SYNC_STAGES + 1);
    localparam spi_mode_e c_MODE = mode_of(CPOL, CPHA);

    logic w_sck_rise, w_sck_fall, w_unused_sck_level;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
        .clk   (clk),
        .nrst  (nrst),
        .pin   (spi_clk),
        .level (w_unused_sck_level),
        .rise  (w_sck_rise),
        .fall  (w_sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .nrst  (nrst),
        .pin   (spi_ss),
        .level (w_ss_level),
        .rise  (w_ss_rise),
        .fall  (w_ss_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .nrst  (nrst),
        .pin   (spi_mosi),
        .level (w_mosi),
        .rise  (w_unused_mosi_rise),
        .fall  (w_unused_mosi_fall)
    );

    logic w_lead, w_trail, w_sample_on_lead, w_sample, w_shift;

    assign w_lead           = lead_is_rise(CPOL) ? w_sck_rise : w_sck_fall;
    assign w_trail          = lead_is_rise(CPOL) ? w_sck_fall : w_sck_rise;
    assign w_sample_on_lead = (c_MODE == SPI_MODE0) || (c_MODE == SPI_MODE2);
    assign w_sample         = w_sample_on_lead ? w_lead  : w_trail;
    assign w_shift          = w_sample_on_lead ? w_trail : w_lead;

    // Synchroniser contents are reset artefacts until SYNC_STAGES real samples
    // have flushed through; arming waits for that so a low ss at reset release
    // cannot be mistaken for a frame start.
    logic [SET_W-1:0] r_settle_cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_settle_cnt <= '0;
        end else if (r_settle_cnt != SET_W'(SYNC_STAGES)) begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
        end
    end

    ctl_state_e r_state, w_state_nxt;
    logic       w_start, w_end;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_DISARMED: begin
                if (w_ss_level && (r_settle_cnt == SET_W'(SYNC_STAGES))) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_BUSY;
                    w_start     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_ARMED;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_DISARMED;
        endcase
    end

    logic [IN_W-1:0]  r_shadow, r_cmd_read;
    logic [OUT_W-1:0] r_out;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [LEN_W-1:0] r_len, w_len;
    logic [7:0]       r_rx_byte;
    logic             r_rx_byte_valid, r_valid, r_frame_err, r_overflow, r_skip_shift;
    logic             w_busy, w_good;

    assign w_busy = (r_state == ST_BUSY);
    assign w_good = (r_bit_idx == 3'd0) && (r_byte_cnt != '0);
    assign w_len  = (r_byte_cnt > CNT_W'(IN_BYTES)) ? LEN_W'(IN_BYTES) : LEN_W'(r_byte_cnt);

    // Frame end takes priority over any sck edge seen in the same cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_shadow        <= '0;
            r_cmd_read      <= '0;
            r_out           <= '0;
            r_bit_idx       <= '0;
            r_byte_cnt      <= '0;
            r_len           <= '0;
            r_rx_byte       <= '0;
            r_rx_byte_valid <= 1'b0;
            r_valid         <= 1'b0;
            r_frame_err     <= 1'b0;
            r_overflow      <= 1'b0;
            r_skip_shift    <= 1'b0;
        end else begin
            r_rx_byte_valid <= 1'b0;
            r_valid         <= 1'b0;
            r_frame_err     <= 1'b0;
            if (w_start) begin
                r_shadow     <= '0;
                r_bit_idx    <= '0;
                r_byte_cnt   <= '0;
                r_out        <= cmd_write;
                r_overflow   <= 1'b0;
                r_skip_shift <= CPHA;
            end else if (w_end) begin
                r_cmd_read  <= r_shadow;
                r_len       <= w_len;
                r_valid     <= w_good;
                r_frame_err <= ~w_good;
            end else if (w_busy) begin
                if (w_sample) begin
                    r_shadow  <= {r_shadow[IN_W-2:0], w_mosi};
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        r_rx_byte       <= {r_shadow[BYTE_W-2:0], w_mosi};
                        r_rx_byte_valid <= 1'b1;
                        if (r_byte_cnt != CNT_W'(IN_BYTES + 1)) begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                    if (r_byte_cnt >= CNT_W'(IN_BYTES)) begin
                        r_overflow <= 1'b1;
                    end
                end
                if (w_shift) begin
                    if (r_skip_shift) begin
                        r_skip_shift <= 1'b0;
                    end else begin
                        r_out <= {r_out[OUT_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso      = w_busy ? r_out[OUT_W-1] : 1'bz;
    assign cmd_read      = r_cmd_read;
    assign cmd_len_bytes = r_len;
    assign valid         = r_valid;
    assign frame_err     = r_frame_err;
    assign overflow      = r_overflow;
    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_byte_valid;
    assign busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_frame
// Description : Directed bench driving all four SPI modes in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame;

    localparam int H = 6;

    logic        clk      = 1'b0;
    logic        nrst     = 1'b0;
    logic        sck_base = 1'b0;
    logic        ss       = 1'b1;
    logic        mosi     = 1'b0;
    logic [47:0] cmd_write = 48'hA5A5_5A5A_F00F;

    wire  [3:0]  miso, valid, frame_err, overflow, rxv, busy;
    wire  [63:0] cmd_read [4];
    wire  [3:0]  len      [4];
    wire  [7:0]  rx_byte  [4];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        localparam bit [1:0] c_M = 2'(m);
        wire sck_m = sck_base ^ c_M[1];
        spi_slave_frame #(
            .IN_BYTES(8), .OUT_BYTES(6), .CPOL(c_M[1]), .CPHA(c_M[0]), .SYNC_STAGES(2)
        ) u_dut (
            .clk           (clk),
            .nrst          (nrst),
            .spi_clk       (sck_m),
            .spi_ss        (ss),
            .spi_mosi      (mosi),
            .spi_miso      (miso[m]),
            .cmd_write     (cmd_write),
            .cmd_read      (cmd_read[m]),
            .cmd_len_bytes (len[m]),
            .valid         (valid[m]),
            .frame_err     (frame_err[m]),
            .overflow      (overflow[m]),
            .rx_byte       (rx_byte[m]),
            .rx_byte_valid (rxv[m]),
            .busy          (busy[m])
        );
    end

    int n_valid [4] = '{default: 0};
    int n_ferr  [4] = '{default: 0};
    int n_rxv   [4] = '{default: 0};
    int b_valid [4], b_ferr [4], b_rxv [4];
    logic [127:0] miso_cap [4];
    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (valid[m])     n_valid[m]++;
            if (frame_err[m]) n_ferr[m]++;
            if (rxv[m])       n_rxv[m]++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_frame();
        for (int m = 0; m < 4; m++) begin
            b_valid[m]  = n_valid[m];
            b_ferr[m]   = n_ferr[m];
            b_rxv[m]    = n_rxv[m];
            miso_cap[m] = '0;
        end
        ss = 1'b0;
        wait_clk(2 * H);
    endtask

    // MISO is captured where the master would sample it: before the leading
    // edge for CPHA=0, before the trailing edge for CPHA=1.
    task automatic send_bits(input logic [127:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            wait_clk(H);
            mosi = data[nbits-1-i];
            wait_clk(H);
            for (int m = 0; m < 4; m++) if (m[0] == 1'b0) miso_cap[m][nbits-1-i] = miso[m];
            sck_base = 1'b1;
            wait_clk(H);
            for (int m = 0; m < 4; m++) if (m[0] == 1'b1) miso_cap[m][nbits-1-i] = miso[m];
            sck_base = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_clk(2 * H);
        ss = 1'b1;
        wait_clk(12);
    endtask

    task automatic check_result(input string name, input logic [63:0] e_rd, input int e_len,
                                input int e_v, input int e_fe, input int e_rxv,
                                input logic [7:0] e_rxb, input logic e_ovf);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s m%0d cmd_read", name, m), {64'h0, cmd_read[m]}, {64'h0, e_rd});
            check($sformatf("%s m%0d len", name, m), 128'(len[m]), 128'(e_len));
            check($sformatf("%s m%0d valid_cnt", name, m), 128'(n_valid[m] - b_valid[m]), 128'(e_v));
            check($sformatf("%s m%0d ferr_cnt", name, m), 128'(n_ferr[m] - b_ferr[m]), 128'(e_fe));
            check($sformatf("%s m%0d rxv_cnt", name, m), 128'(n_rxv[m] - b_rxv[m]), 128'(e_rxv));
            check($sformatf("%s m%0d rx_byte", name, m), 128'(rx_byte[m]), 128'(e_rxb));
            check($sformatf("%s m%0d overflow", name, m), 128'(overflow[m]), 128'(e_ovf));
            check($sformatf("%s m%0d busy", name, m), 128'(busy[m]), 128'(0));
        end
    endtask

    initial begin
        wait_clk(4);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset m%0d valid", m), 128'(valid[m]), 128'(0));
            check($sformatf("reset m%0d busy", m), 128'(busy[m]), 128'(0));
            check($sformatf("reset m%0d cmd_read", m), {64'h0, cmd_read[m]}, 128'(0));
            check($sformatf("reset m%0d len", m), 128'(len[m]), 128'(0));
            check($sformatf("reset m%0d overflow", m), 128'(overflow[m]), 128'(0));
        end
        nrst = 1'b1;
        wait_clk(8);

        // Full 8-byte frame in every mode
        begin_frame();
        send_bits(128'h0123_4567_89AB_CDEF, 64);
        end_frame();
        check_result("frame8", 64'h0123_4567_89AB_CDEF, 8, 1, 0, 8, 8'hEF, 1'b0);
        for (int m = 0; m < 4; m++)
            check($sformatf("frame8 m%0d miso", m), miso_cap[m], {64'h0, cmd_write, 16'h0});

        // 10-byte frame: overflow, newest 8 bytes kept, MISO zero after bit 48
        begin_frame();
        send_bits(128'hFEDC_0123_4567_89AB_CDEF, 80);
        end_frame();
        check_result("ovf", 64'h0123_4567_89AB_CDEF, 8, 1, 0, 10, 8'hEF, 1'b1);
        for (int m = 0; m < 4; m++)
            check($sformatf("ovf m%0d miso", m), miso_cap[m], {48'h0, cmd_write, 32'h0});

        // 13-bit frame: {0x3C, 5'b10101}
        begin_frame();
        send_bits(128'h795, 13);
        end_frame();
        check_result("short", 64'h795, 1, 0, 1, 1, 8'h3C, 1'b0);

        // ss rise coincides with a ninth sck edge: the edge is dropped
        begin_frame();
        send_bits(128'h5A, 8);
        wait_clk(H);
        mosi = 1'b1;
        wait_clk(H);
        sck_base = 1'b1;
        ss       = 1'b1;
        wait_clk(H);
        sck_base = 1'b0;
        wait_clk(12);
        check_result("ss_sck", 64'h5A, 1, 1, 0, 1, 8'h5A, 1'b0);

        // Reset mid-frame, released with ss low: no frame until ss cycles
        begin_frame();
        send_bits(128'hABCDE, 20);
        nrst = 1'b0;
        wait_clk(3);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("midrst m%0d busy", m), 128'(busy[m]), 128'(0));
            check($sformatf("midrst m%0d cmd_read", m), {64'h0, cmd_read[m]}, 128'(0));
        end
        nrst = 1'b1;
        wait_clk(4);
        send_bits(128'hFF, 8);
        for (int m = 0; m < 4; m++)
            check($sformatf("disarmed m%0d busy", m), 128'(busy[m]), 128'(0));
        end_frame();
        for (int m = 0; m < 4; m++) begin
            check($sformatf("disarmed m%0d valid_cnt", m), 128'(n_valid[m] - b_valid[m]), 128'(0));
            check($sformatf("disarmed m%0d ferr_cnt", m), 128'(n_ferr[m] - b_ferr[m]), 128'(0));
        end
        begin_frame();
        send_bits(128'hC396, 16);
        end_frame();
        check_result("rearm", 64'hC396, 2, 1, 0, 2, 8'h96, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
